// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction fetch stage.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [5:0]  OPC_J        = 6'b000010;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  typedef enum logic [2:0] {
    SEL_BRANCH,
    SEL_STALL,
    SEL_DONE,
    SEL_JUMP,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux: branch > stall > end-of-program > jump > pc+4.
module next_pc_select
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        stall_i,
  input  logic        done_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] pc4_o,
  output pc_sel_e     sel_o
);

  logic [31:0] jump_target;

  assign pc4_o       = pc_i + 32'd4;
  assign jump_target = {pc4_o[31:28], instr_i[25:0], 2'b00};

  always_comb begin
    next_pc_o = pc4_o;
    sel_o     = SEL_SEQ;
    if (branch_taken_i) begin
      next_pc_o = branch_target_i & ~32'h3;
      sel_o     = SEL_BRANCH;
    end else if (stall_i) begin
      next_pc_o = pc_i;
      sel_o     = SEL_STALL;
    end else if (done_i) begin
      // Past the program: park the PC and ignore whatever the memory returns.
      next_pc_o = pc_i;
      sel_o     = SEL_DONE;
    end else if (instr_i[31:26] == OPC_J) begin
      next_pc_o = jump_target;
      sel_o     = SEL_JUMP;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-cycle instruction fetch with IF/ID pipeline register and zero-penalty J decode.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned IMEM_BYTES = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        done,
  output logic [15:0] fetch_count
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  logic [31:0] pc_q, pc_d, pc4;
  ifid_t       ifid_q, ifid_d;
  logic [15:0] cnt_q, cnt_d;
  pc_sel_e     sel;

  assign done = (pc_q >= IMEM_LIMIT);

  next_pc_select u_next_pc (
    .pc_i            (pc_q),
    .instr_i         (imem_instr),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .stall_i         (stall),
    .done_i          (done),
    .next_pc_o       (pc_d),
    .pc4_o           (pc4),
    .sel_o           (sel)
  );

  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    case (sel)
      SEL_BRANCH, SEL_DONE: ifid_d = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      SEL_STALL:            ifid_d = ifid_q;
      SEL_JUMP, SEL_SEQ: begin
        // The jump word itself is issued, so a J costs no bubble.
        ifid_d = '{instr: imem_instr, pc4: pc4, valid: 1'b1};
        cnt_d  = cnt_q + 16'd1;
      end
      default:              ifid_d = ifid_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ifid_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit running a 7-word program.
module tb_instruction_fetch_unit;

  localparam logic [31:0] I0 = 32'h8C01_0000;
  localparam logic [31:0] I1 = 32'h8C02_0001;
  localparam logic [31:0] I2 = 32'h0022_1818;
  localparam logic [31:0] IJ = 32'h0800_0005;
  localparam logic [31:0] I4 = 32'h0043_2018;
  localparam logic [31:0] I5 = 32'h0003_1042;
  localparam logic [31:0] I6 = 32'hAC03_0008;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
    logic        done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_instr, pc, ifid_instr, ifid_pc4;
  logic        ifid_valid, done;
  logic [15:0] fetch_count;
  logic [31:0] mem [0:6];

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Past the program the memory returns a J word, which the DUT must ignore.
  always_comb imem_instr = (imem_addr < 32'd28) ? mem[imem_addr[4:2]] : 32'h0800_0001;

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(28)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .done          (done),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic st, input logic bt,
                      input logic [31:0] tgt, input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid, input logic [15:0] e_cnt,
                      input logic e_done);
    exp_t e;
    reset = rst; stall = st; branch_taken = bt; branch_target = tgt;
    sb.push_back('{e_pc, e_instr, e_pc4, e_valid, e_cnt, e_done});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},    pc,                 e.pc);
    chk({tag, ".addr"},  imem_addr,          e.pc);
    chk({tag, ".instr"}, ifid_instr,         e.instr);
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, e.valid});
    chk({tag, ".cnt"},   {16'h0, fetch_count}, {16'h0, e.cnt});
    chk({tag, ".done"},  {31'h0, done},       {31'h0, e.done});
    if (e.valid) chk({tag, ".pc4"}, ifid_pc4, e.pc4);
  endtask

  initial begin
    mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = IJ;
    mem[4] = I4; mem[5] = I5; mem[6] = I6;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;

    step("reset",  1, 0, 0, 0, 32'd0,  32'h0, 32'd0,  0, 16'd0, 0);
    step("f0",     0, 0, 0, 0, 32'd4,  I0,    32'd4,  1, 16'd1, 0);
    step("f4",     0, 0, 0, 0, 32'd8,  I1,    32'd8,  1, 16'd2, 0);
    for (int i = 0; i < 3; i++)
      step("stall8", 0, 1, 0, 0, 32'd8, I1,   32'd8,  1, 16'd2, 0);
    step("f8",     0, 0, 0, 0, 32'd12, I2,    32'd12, 1, 16'd3, 0);
    step("jump12", 0, 0, 0, 0, 32'd20, IJ,    32'd16, 1, 16'd4, 0);
    step("f20",    0, 0, 0, 0, 32'd24, I5,    32'd24, 1, 16'd5, 0);
    step("f24",    0, 0, 0, 0, 32'd28, I6,    32'd28, 1, 16'd6, 1);
    for (int i = 0; i < 5; i++)
      step("idle",   0, 0, 0, 0, 32'd28, 32'h0, 32'd0, 0, 16'd6, 1);
    step("br_done",  0, 0, 1, 32'h0,  32'd0,  32'h0, 32'd0,  0, 16'd6, 0);
    step("f0b",      0, 0, 0, 0,      32'd4,  I0,    32'd4,  1, 16'd7, 0);
    step("br_stall", 0, 1, 1, 32'h15, 32'h14, 32'h0, 32'd0,  0, 16'd7, 0);
    step("f20b",     0, 0, 0, 0,      32'd24, I5,    32'd24, 1, 16'd8, 0);
    step("br24",     0, 0, 1, 32'h4,  32'd4,  32'h0, 32'd0,  0, 16'd8, 0);
    step("f4b",      0, 0, 0, 0,      32'd8,  I1,    32'd8,  1, 16'd9, 0);
    step("f8b",      0, 0, 0, 0,      32'd12, I2,    32'd12, 1, 16'd10, 0);
    step("br_vs_j",  0, 0, 1, 32'h8,  32'd8,  32'h0, 32'd0,  0, 16'd10, 0);
    step("f8c",      0, 0, 0, 0,      32'd12, I2,    32'd12, 1, 16'd11, 0);
    step("stall12",  0, 1, 0, 0,      32'd12, I2,    32'd12, 1, 16'd11, 0);
    step("rst_stall",1, 1, 1, 32'h10, 32'd0,  32'h0, 32'd0,  0, 16'd0, 0);
    step("f0c",      0, 0, 0, 0,      32'd4,  I0,    32'd4,  1, 16'd1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address fetched first after reset.
REQ-002 Parameter: IMEM_BYTES, 28, program size in bytes; fetch addresses >= IMEM_BYTES are end-of-program.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  hazard stall from ID; hold PC and IF/ID.
REQ-006 Port: branch_taken  input  1  EX-stage branch resolved taken.
REQ-007 Port: branch_target  input  32  EX-stage branch byte address.
REQ-008 Port: imem_addr  output  32  byte address to instruction memory (equals pc).
REQ-009 Port: imem_instr  input  32  big-endian word returned combinationally for imem_addr.
REQ-010 Port: pc  output  32  current fetch PC.
REQ-011 Port: ifid_instr  output  32  IF/ID instruction register.
REQ-012 Port: ifid_pc4  output  32  IF/ID PC+4 register.
REQ-013 Port: ifid_valid  output  1  IF/ID holds a real instruction.
REQ-014 Port: done  output  1  pc >= IMEM_BYTES; no further instructions issued.
REQ-015 Port: fetch_count  output  16  count of instructions written to IF/ID as valid.

Function
REQ-016 Fetch SHALL be single-cycle: imem_instr sampled at pc, written to IF/ID on the same edge.
REQ-017 Next-PC priority SHALL be: branch_taken > stall > in-IF jump > pc+4.
REQ-018 branch_taken SHALL load pc <= {branch_target[31:2],2'b00} and write IF/ID with NOP (32'h0), ifid_valid=0, regardless of stall.
REQ-019 stall (without branch_taken) SHALL hold pc, ifid_instr, ifid_pc4, ifid_valid unchanged.
REQ-020 Fetched opcode imem_instr[31:26]==6'b000010 SHALL load pc <= {pc4[31:28], imem_instr[25:0], 2'b00} next cycle; jump word itself enters IF/ID valid (zero-penalty jump).
REQ-021 Otherwise pc SHALL advance by 4; IF/ID <= {imem_instr, pc+4}, ifid_valid=1.
REQ-022 When done=1 IF/ID SHALL receive NOP with ifid_valid=0, pc SHALL hold, jump decode SHALL be suppressed; a branch_taken still redirects and clears done.
REQ-023 fetch_count SHALL increment on every edge writing ifid_valid=1, wrap 16'hFFFF->0, and hold on stall/bubble.
REQ-024 pc+4 SHALL wrap modulo 2^32; no overflow flag.

Reset
REQ-025 On reset=1 at an edge: pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, fetch_count=0; done recomputed from pc.
REQ-026 reset SHALL override branch_taken, stall and jump in the same cycle; reset asserted mid-stall discards held IF/ID contents.

Structure
REQ-027 Package mips_pkg SHALL hold NOP_INSTR, OPC_J, RESET_PC default, and the IF/ID record typedef.
REQ-028 One combinational sub-module next_pc_select SHALL implement the REQ-017 priority mux; registers stay in the top.

Verification
REQ-029 Reset then run with program lw,lw,mul,j 5(0x08000005 at 12),mul,srl,sw -> pc sequence 0,4,8,12,20,24,28; byte 16 never fetched; fetch_count=6 at done.
REQ-030 stall high 3 cycles at pc=8 -> pc stays 8, ifid_instr stays 0x8C020001, fetch_count unchanged; resumes at 12.
REQ-031 branch_taken=1, branch_target=0x15 while stall=1 -> pc=0x14 next cycle, ifid_valid=0, ifid_instr=0.
REQ-032 pc=24 with branch_taken to 4 in same cycle jump-free -> IF/ID bubble, next fetch at 4; jump word at 12 with branch_taken same cycle -> branch target wins.
REQ-033 Reach done (pc=28) 5 cycles -> ifid_valid=0 each cycle, pc holds; then branch_taken to 0 -> done=0, fetch resumes.
REQ-034 reset asserted during stall at pc=12 -> next cycle pc=0, ifid_valid=0, fetch_count=0.
